// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N-channel stream multiplexer: mode values and FSM state encoding.
package stream_mux_pkg;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: grants the first requesting channel after ptr, wrapping modulo CHANNELS.
module rr_arbiter #(
    parameter  int CHANNELS  = 4,
    localparam int SEL_WIDTH = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0]  req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic                 gnt_valid,
    output logic [SEL_WIDTH-1:0] gnt_idx
);

    logic [SEL_WIDTH:0]   sum;
    logic [SEL_WIDTH-1:0] idx;

    // Walk offsets from farthest to nearest so the closest requester after ptr is the last to win.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            sum = {1'b0, ptr} + (SEL_WIDTH+1)'(i);
            if (sum >= (SEL_WIDTH+1)'(CHANNELS)) begin
                sum = sum - (SEL_WIDTH+1)'(CHANNELS);
            end
            idx = sum[SEL_WIDTH-1:0];
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream mux with static or round-robin selection, per-packet grant lock
// and a registered output stage. Handshake: a beat moves on a cycle where valid and ready are both high.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int CHANNELS   = 4,
    localparam int SEL_WIDTH  = $clog2(CHANNELS)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           mode_i,
    input  logic [SEL_WIDTH-1:0]           select_i,
    input  logic [CHANNELS-1:0]            s_valid_i,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_data_i,
    input  logic [CHANNELS-1:0]            s_last_i,
    output logic [CHANNELS-1:0]            s_ready_o,
    output logic                           m_valid_o,
    output logic [DATA_WIDTH-1:0]          m_data_o,
    output logic                           m_last_o,
    output logic [SEL_WIDTH-1:0]           m_sel_o,
    input  logic                           m_ready_i,
    output logic                           state_o
);

    state_t                state;
    logic [SEL_WIDTH-1:0]  grant;
    logic [SEL_WIDTH-1:0]  rr_ptr;

    logic                  arb_valid;
    logic [SEL_WIDTH-1:0]  arb_idx;
    logic                  cand_valid;
    logic [SEL_WIDTH-1:0]  cand_idx;

    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;
    logic                  out_free;
    logic                  accept;
    logic                  consume;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .req       (s_valid_i),
        .ptr       (rr_ptr),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    // Static mode bypasses the arbiter; an out-of-range index simply never grants.
    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = select_i;
        if (mode_i == MODE_RR) begin
            cand_valid = arb_valid;
            cand_idx   = arb_idx;
        end else if ({1'b0, select_i} < (SEL_WIDTH+1)'(CHANNELS)) begin
            cand_valid = s_valid_i[select_i];
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant == SEL_WIDTH'(k)) begin
                sel_valid = s_valid_i[k];
                sel_data  = s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                sel_last  = s_last_i[k];
            end
        end
    end

    assign out_free = !m_valid_o || m_ready_i;
    assign accept   = (state == ST_LOCKED) && sel_valid && out_free;
    assign consume  = m_valid_o && m_ready_i;
    assign state_o  = state;

    always_comb begin
        s_ready_o = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            s_ready_o[k] = (state == ST_LOCKED) && (grant == SEL_WIDTH'(k)) && out_free;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            grant     <= '0;
            rr_ptr    <= SEL_WIDTH'(CHANNELS - 1);
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            m_last_o  <= 1'b0;
            m_sel_o   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cand_valid) begin
                        grant <= cand_idx;
                        state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (accept && sel_last) begin
                        state  <= ST_IDLE;
                        rr_ptr <= grant;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A load and a consume in the same cycle replace the register and keep valid high.
            if (accept) begin
                m_valid_o <= 1'b1;
                m_data_o  <= sel_data;
                m_last_o  <= sel_last;
                m_sel_o   <= grant;
            end else if (consume) begin
                m_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: directed scenarios plus randomized packet phases scored against a packet-level model.
module tb_stream_mux_n;

    localparam int DW  = 8;
    localparam int CH  = 4;
    localparam int SW  = 2;
    localparam int CH3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic            mode;
    logic [SW-1:0]   sel;
    logic [CH-1:0]   s_valid;
    logic [CH*DW-1:0] s_data;
    logic [CH-1:0]   s_last;
    logic [CH-1:0]   s_ready;
    logic            m_valid;
    logic [DW-1:0]   m_data;
    logic            m_last;
    logic [SW-1:0]   m_sel;
    logic            m_ready;
    logic            state;

    logic             mode3;
    logic [1:0]       sel3;
    logic [CH3-1:0]   s3_valid;
    logic [CH3*DW-1:0] s3_data;
    logic [CH3-1:0]   s3_last;
    logic [CH3-1:0]   s3_ready;
    logic             m3_valid;
    logic [DW-1:0]    m3_data;
    logic             m3_last;
    logic [1:0]       m3_sel;
    logic             m3_ready;
    logic             state3;

    stream_mux_n #(.DATA_WIDTH(DW), .CHANNELS(CH)) dut (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .select_i(sel),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last), .s_ready_o(s_ready),
        .m_valid_o(m_valid), .m_data_o(m_data), .m_last_o(m_last), .m_sel_o(m_sel),
        .m_ready_i(m_ready), .state_o(state)
    );

    stream_mux_n #(.DATA_WIDTH(DW), .CHANNELS(CH3)) dut3 (
        .clk_i(clk), .rst_i(rst), .mode_i(mode3), .select_i(sel3),
        .s_valid_i(s3_valid), .s_data_i(s3_data), .s_last_i(s3_last), .s_ready_o(s3_ready),
        .m_valid_o(m3_valid), .m_data_o(m3_data), .m_last_o(m3_last), .m_sel_o(m3_sel),
        .m_ready_i(m3_ready), .state_o(state3)
    );

    // Source storage: {last, data} per beat, per channel.
    logic [8:0]  src_mem [CH][64];
    int          src_rd [CH];
    int          src_wr [CH];
    logic [10:0] exp_q[$];
    int          out_cyc[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_ptr = CH - 1;
    int rdy_mode = 0;
    int stall_from = 0;
    int stall_to = 0;
    int stall_cycles = 0;
    int load_cyc = 0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [SW-1:0] prev_sel;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic add_pkt(input int ch, input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            src_mem[ch][src_wr[ch]] = {(i == len - 1), 8'(base + 8'(i))};
            src_wr[ch]++;
        end
    endtask

    // Packet-level model: static serves only the selected channel; round-robin serves whole packets,
    // searching from the channel after the last one that finished a packet.
    task automatic build_expected(input logic md, input int sl);
        int rd [CH];
        int c;
        int found;
        logic [8:0] b;
        for (int k = 0; k < CH; k++) rd[k] = src_rd[k];
        if (md == 1'b0) begin
            while (rd[sl] < src_wr[sl]) begin
                b = src_mem[sl][rd[sl]];
                exp_q.push_back({2'(sl), b});
                rd[sl]++;
                if (b[8]) model_ptr = sl;
            end
        end else begin
            forever begin
                found = -1;
                for (int i = CH; i >= 1; i--) begin
                    c = (model_ptr + i) % CH;
                    if (rd[c] < src_wr[c]) found = c;
                end
                if (found < 0) break;
                do begin
                    b = src_mem[found][rd[found]];
                    exp_q.push_back({2'(found), b});
                    rd[found]++;
                end while (!b[8]);
                model_ptr = found;
            end
        end
    endtask

    task automatic step();
        logic [10:0] e;
        @(negedge clk);
        cyc++;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 3) != 0);
            default: m_ready = !(cyc >= stall_from && cyc < stall_to);
        endcase
        for (int k = 0; k < CH; k++) begin
            s_valid[k] = (src_rd[k] < src_wr[k]);
            s_data[k*DW +: DW] = s_valid[k] ? src_mem[k][src_rd[k]][7:0] : 8'h00;
            s_last[k] = s_valid[k] ? src_mem[k][src_rd[k]][8] : 1'b0;
        end
        #1;
        check_eq("ready_onehot", ($countones(s_ready) <= 1), 1);
        if (prev_hold) begin
            check_eq("hold_valid", m_valid, 1);
            check_eq("hold_data", m_data, prev_data);
            check_eq("hold_last", m_last, prev_last);
            check_eq("hold_sel", m_sel, prev_sel);
        end
        if (m_valid && !m_ready) begin
            check_eq("stall_ready", s_ready, 0);
            stall_cycles++;
        end
        for (int k = 0; k < CH; k++) begin
            if (s_valid[k] && s_ready[k]) src_rd[k]++;
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_beat", {m_sel, m_last, m_data}, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_data", m_data, e[7:0]);
                check_eq("out_last", m_last, e[8]);
                check_eq("out_sel", m_sel, e[10:9]);
            end
            out_cyc.push_back(cyc);
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
        prev_last = m_last;
        prev_sel  = m_sel;
    endtask

    task automatic clear_sources();
        for (int k = 0; k < CH; k++) begin
            src_rd[k] = 0;
            src_wr[k] = 0;
        end
    endtask

    task automatic run_phase(input logic md, input int sl, input int budget);
        int n;
        exp_q.delete();
        out_cyc.delete();
        stall_cycles = 0;
        mode = md;
        sel = SW'(sl);
        build_expected(md, sl);
        load_cyc = cyc + 1;
        n = 0;
        do begin
            step();
            n++;
        end while ((exp_q.size() != 0 || m_valid) && n < budget);
        check_eq("phase_drained", exp_q.size(), 0);
        check_eq("phase_idle", m_valid, 0);
        clear_sources();
        step();
        step();
    endtask

    initial begin
        rst = 1'b1;
        mode = 1'b0; sel = '0; s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b1;
        mode3 = 1'b0; sel3 = '0; s3_valid = '0; s3_data = '0; s3_last = '0; m3_ready = 1'b1;
        clear_sources();
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_m_valid", m_valid, 0);
        check_eq("reset_m_data", m_data, 0);
        check_eq("reset_m_sel", m_sel, 0);
        check_eq("reset_state", state, 0);
        check_eq("reset3_m_valid", m3_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        // Static ch2, three beats: first beat two cycles after valid, then back-to-back.
        add_pkt(2, 3, 8'hA1);
        run_phase(1'b0, 2, 50);
        check_eq("t2_beats", out_cyc.size(), 3);
        if (out_cyc.size() == 3) begin
            check_eq("t2_latency", out_cyc[0] - load_cyc, 2);
            check_eq("t2_beat2", out_cyc[1] - out_cyc[0], 1);
            check_eq("t2_beat3", out_cyc[2] - out_cyc[0], 2);
        end

        // Asynchronous reset in the middle of a packet.
        exp_q.delete();
        mode = 1'b0;
        sel = 2'd1;
        add_pkt(1, 6, 8'h30);
        build_expected(1'b0, 1);
        repeat (4) step();
        check_eq("pre_reset_valid", m_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_m_last", m_last, 0);
        check_eq("rst_m_sel", m_sel, 0);
        check_eq("rst_s_ready", s_ready, 0);
        check_eq("rst_state", state, 0);
        clear_sources();
        exp_q.delete();
        s_valid = '0;
        model_ptr = CH - 1;
        prev_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin, single-beat packets on every channel: 0,1,2,3,0,1,2,3 with one bubble each.
        for (int k = 0; k < CH; k++) begin
            add_pkt(k, 1, 8'(8'h10 * k));
            add_pkt(k, 1, 8'(8'h10 * k + 8'h08));
        end
        run_phase(1'b1, 0, 100);
        check_eq("t3_beats", out_cyc.size(), 8);
        for (int i = 0; i + 1 < out_cyc.size(); i++) begin
            check_eq("t3_bubble", out_cyc[i+1] - out_cyc[i], 2);
        end

        // Packet lock: pointer parked on ch0, then ch1 holds the grant for four beats, then ch3, then ch0.
        add_pkt(0, 1, 8'h40);
        run_phase(1'b0, 0, 50);
        add_pkt(0, 1, 8'h41);
        add_pkt(1, 4, 8'h11);
        add_pkt(3, 1, 8'h33);
        run_phase(1'b1, 0, 100);
        check_eq("t4_beats", out_cyc.size(), 6);

        // Backpressure: five stalled cycles mid-packet.
        add_pkt(2, 5, 8'h50);
        stall_from = cyc + 1 + 4;
        stall_to = stall_from + 5;
        rdy_mode = 2;
        run_phase(1'b0, 2, 100);
        check_eq("t5_beats", out_cyc.size(), 5);
        check_eq("t5_stalls", stall_cycles, 5);
        rdy_mode = 0;

        // Three-channel instance: select 3 is out of range, select 0 gets ch0.
        @(negedge clk);
        mode3 = 1'b0;
        sel3 = 2'd3;
        s3_valid = 3'b111;
        s3_last = 3'b111;
        s3_data = {8'h7A, 8'h6B, 8'h5C};
        repeat (6) begin
            @(negedge clk);
            #1;
            check_eq("oor_m_valid", m3_valid, 0);
            check_eq("oor_s_ready", s3_ready, 0);
            check_eq("oor_state", state3, 0);
        end
        sel3 = 2'd0;
        begin
            int got;
            got = 0;
            for (int i = 0; i < 6 && got == 0; i++) begin
                @(negedge clk);
                #1;
                if (m3_valid) begin
                    got = 1;
                    check_eq("sel0_data", m3_data, 8'h5C);
                    check_eq("sel0_sel", m3_sel, 0);
                    check_eq("sel0_last", m3_last, 1);
                end
            end
            check_eq("sel0_granted", got, 1);
        end
        s3_valid = '0;

        // Randomized phases: random mode, selection, packet mix and downstream readiness.
        rdy_mode = 1;
        for (int it = 0; it < 24; it++) begin
            logic md;
            int sl;
            md = 1'($urandom_range(0, 1));
            sl = $urandom_range(0, CH - 1);
            for (int k = 0; k < CH; k++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) add_pkt(k, $urandom_range(1, 4), 8'($urandom));
            end
            run_phase(md, sl, 3000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
